poly_reg_bank_ctrl: RTL
=======================

# poly_reg_bank_ctrl

Sequencer for the AMNS polynomial register bank. It accepts a word-serial operand stream (A, B, M, M'0) over a valid/ready port and routes it into the bank's input registers. It then drives the bank's rotate/shift controls for one multiplication schedule, captures the datapath result slices into RES, and streams RES back out word-serially with back-pressure. It sits between the host/DMA word interface and the register bank plus DSP datapath.

## Interface
- WORD_WIDTH, 17, DSP word width
- N, 5, coefficients per AMNS polynomial
- S, 4, words per coefficient
- clock  in  1  clock
- reset  in  1  synchronous, active-high
- start_i  in  1  begin one operation; ignored unless in IDLE
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse after the last RES word is accepted
- in_valid_i / in_ready_o  in/out  1  operand word handshake
- in_data_i  in  WORD_WIDTH  operand word, LSW first
- out_valid_o / out_ready_i  out/in  1  result word handshake
- out_data_o  out  WORD_WIDTH  result word (= RES_reg_dout_i)
- res_valid_i  in  1  datapath presents one N-word RES slice this cycle
- INPUT_reg_sel_o  out  2  00 A, 01 B, 10 M, 11 M'0
- INPUT_reg_en_o  out  1  bank input write enable
- INPUT_reg_din_o  out  WORD_WIDTH  = in_data_i
- load_RES_reg_en_o, store_RES_reg_en_o  out  1  RES slice load / RES word shift-out
- A_reg_coeff_rot_o  out  S  one-hot A section rotate
- B_reg_shift_o, M_reg_shift_o, M_prime_0_rot_o  out  1  bank shift/rotate strobes
- RES_reg_dout_i  in  WORD_WIDTH  bank RES output word

## Operation
- States: IDLE, LOAD, COMPUTE, WAIT_RES, STORE, DONE.
- IDLE: start_i=1 -> LOAD, sel=00, word_cnt=0.
- LOAD:
  - in_ready_o=1; INPUT_reg_en_o = in_valid_i & in_ready_o.
  - Each accepted word increments word_cnt.
  - Section lengths: N*S words for sel 00/01/10, N words for sel 11.
  - Last word of a section: word_cnt=0 and sel increments.
  - Last M'0 word -> COMPUTE.
  - Gaps in in_valid_i only stall the load.
- COMPUTE: N*S cycles, outer j=0..S-1, inner i=0..N-1.
  - Every cycle: A_reg_coeff_rot_o = 1<<j, M_prime_0_rot_o=1.
  - When i==N-1: B_reg_shift_o=1, M_reg_shift_o=1.
  - After j=S-1, i=N-1 -> WAIT_RES.
- WAIT_RES:
  - load_RES_reg_en_o = res_valid_i.
  - Count S accepted slices, then -> STORE.
- STORE:
  - out_valid_o=1; store_RES_reg_en_o = out_valid_o & out_ready_i.
  - After N*S accepted words -> DONE.
- DONE: done_o=1 for one cycle, then -> IDLE.
- Outputs are decoded from state and counters. A strobe is never active outside its state.
- start_i while busy: ignored, no effect on counters.
- Reset (any state, including mid-LOAD or mid-STORE):
  - Next cycle: IDLE, all counters 0.
  - All outputs 0 except INPUT_reg_din_o/out_data_o, which remain combinational pass-throughs.
  - Partially loaded bank contents are don't-care.

## Timing
- start_i sampled high at edge t -> in_ready_o high from t+1.
- Minimum load: 3*N*S+N cycles (65 at defaults).
- COMPUTE is exactly N*S cycles (20), with no stall.
- WAIT_RES length is set by res_valid_i; minimum S cycles.
- STORE minimum N*S cycles. out_valid_o stays high under back-pressure; out_data_o stays stable until accepted.
- done_o asserts the cycle after the final store handshake. busy_o falls the cycle after that.
- Counters: word_cnt $clog2(N*S) bits, j $clog2(S), i $clog2(N). Wrap is explicit at the boundary, never by overflow.

## Structure
- Shared package poly_ctrl_pkg:
  - state enum;
  - SEL_A/SEL_B/SEL_M/SEL_MP0 encodings (2'b00..2'b11), also used by POLY_reg_bank;
  - section-length function of N, S.
- Single flat module; no sub-module is warranted (one FSM plus three counters).

## Test plan
- Default params, in_valid_i always 1, 65 words 0..64 -> sel 00 for words 0–19, 01 for 20–39, 10 for 40–59, 11 for 60–64; in_ready_o low the cycle after word 64; bank A/B/M/M'0 contents match.
- in_valid_i toggled 1/0 during load -> 130 cycles, same bank contents; no extra INPUT_reg_en_o pulses.
- COMPUTE -> 20 cycles; A_reg_coeff_rot_o = 0001 for cycles 0–4, 0010 for 5–9, 0100 for 10–14, 1000 for 15–19; B/M shift high on cycles 4, 9, 14, 19 only.
- res_valid_i pulsed 4 times with gaps, random slices, then out_ready_i high every third cycle -> 20 words equal to the slices in LSW-first order; done_o pulses exactly once.
- Reset asserted after word 30 of load, then a new full operation -> clean restart from sel 00 with correct result.
- start_i held high throughout an operation -> exactly one operation, busy_o continuous, done_o single pulse, then a new operation starts.

Source files
------------

// File: rtl/poly_ctrl_pkg.sv
// Shared definitions for the AMNS polynomial register bank sequencer.
// The SEL_* encodings are also decoded by POLY_reg_bank.
package poly_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_WAIT_RES,
    ST_STORE,
    ST_DONE
  } ctrl_state_e;

  localparam logic [1:0] SEL_A   = 2'b00;
  localparam logic [1:0] SEL_B   = 2'b01;
  localparam logic [1:0] SEL_M   = 2'b10;
  localparam logic [1:0] SEL_MP0 = 2'b11;

  // Words in one input section: full polynomials carry N*S words, M'0 only N.
  function automatic int unsigned sec_len(input int unsigned n, input int unsigned s,
                                          input logic [1:0] sel);
    return (sel == SEL_MP0) ? n : n * s;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/poly_reg_bank_ctrl.sv
// Sequencer: loads A/B/M/M'0 word-serially, drives one multiplication schedule,
// collects S result slices and streams RES back out with back-pressure.
module poly_reg_bank_ctrl
  import poly_ctrl_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 17,
  parameter int unsigned N          = 5,
  parameter int unsigned S          = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [WORD_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [WORD_WIDTH-1:0] out_data_o,
  input  logic                  res_valid_i,
  output logic [1:0]            INPUT_reg_sel_o,
  output logic                  INPUT_reg_en_o,
  output logic [WORD_WIDTH-1:0] INPUT_reg_din_o,
  output logic                  load_RES_reg_en_o,
  output logic                  store_RES_reg_en_o,
  output logic [S-1:0]          A_reg_coeff_rot_o,
  output logic                  B_reg_shift_o,
  output logic                  M_reg_shift_o,
  output logic                  M_prime_0_rot_o,
  input  logic [WORD_WIDTH-1:0] RES_reg_dout_i
);

  localparam int unsigned CW = cnt_width(N * S);
  localparam int unsigned JW = cnt_width(S);
  localparam int unsigned IW = cnt_width(N);

  localparam logic [CW-1:0] LAST_WORD = CW'(N * S - 1);
  localparam logic [JW-1:0] LAST_J    = JW'(S - 1);
  localparam logic [IW-1:0] LAST_I    = IW'(N - 1);

  ctrl_state_e   state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic [JW-1:0] j_q, j_d;
  logic [IW-1:0] i_q, i_d;
  logic          last_in_sec;

  assign INPUT_reg_din_o = in_data_i;
  assign out_data_o      = RES_reg_dout_i;
  assign busy_o          = (state_q != ST_IDLE);
  assign last_in_sec     = (word_cnt_q == CW'(sec_len(N, S, sel_q) - 1));

  always_comb begin
    state_d            = state_q;
    sel_d              = sel_q;
    word_cnt_d         = word_cnt_q;
    j_d                = j_q;
    i_d                = i_q;
    done_o             = 1'b0;
    in_ready_o         = 1'b0;
    out_valid_o        = 1'b0;
    INPUT_reg_sel_o    = SEL_A;
    INPUT_reg_en_o     = 1'b0;
    load_RES_reg_en_o  = 1'b0;
    store_RES_reg_en_o = 1'b0;
    A_reg_coeff_rot_o  = '0;
    B_reg_shift_o      = 1'b0;
    M_reg_shift_o      = 1'b0;
    M_prime_0_rot_o    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d    = ST_LOAD;
          sel_d      = SEL_A;
          word_cnt_d = '0;
          j_d        = '0;
          i_d        = '0;
        end
      end

      ST_LOAD: begin
        in_ready_o      = 1'b1;
        INPUT_reg_sel_o = sel_q;
        INPUT_reg_en_o  = in_valid_i;
        if (in_valid_i) begin
          if (last_in_sec) begin
            word_cnt_d = '0;
            if (sel_q == SEL_MP0) begin
              sel_d   = SEL_A;
              state_d = ST_COMPUTE;
            end else begin
              sel_d = sel_q + 2'd1;
            end
          end else begin
            word_cnt_d = word_cnt_q + CW'(1);
          end
        end
      end

      // j selects the A coefficient section; B/M advance once per full i sweep.
      ST_COMPUTE: begin
        A_reg_coeff_rot_o = S'(1) << j_q;
        M_prime_0_rot_o   = 1'b1;
        if (i_q == LAST_I) begin
          B_reg_shift_o = 1'b1;
          M_reg_shift_o = 1'b1;
          i_d           = '0;
          if (j_q == LAST_J) begin
            j_d     = '0;
            state_d = ST_WAIT_RES;
          end else begin
            j_d = j_q + JW'(1);
          end
        end else begin
          i_d = i_q + IW'(1);
        end
      end

      // j is reused here as the slice counter.
      ST_WAIT_RES: begin
        load_RES_reg_en_o = res_valid_i;
        if (res_valid_i) begin
          if (j_q == LAST_J) begin
            j_d        = '0;
            word_cnt_d = '0;
            state_d    = ST_STORE;
          end else begin
            j_d = j_q + JW'(1);
          end
        end
      end

      ST_STORE: begin
        out_valid_o        = 1'b1;
        store_RES_reg_en_o = out_ready_i;
        if (out_ready_i) begin
          if (word_cnt_q == LAST_WORD) begin
            word_cnt_d = '0;
            state_d    = ST_DONE;
          end else begin
            word_cnt_d = word_cnt_q + CW'(1);
          end
        end
      end

      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sel_q      <= SEL_A;
      word_cnt_q <= '0;
      j_q        <= '0;
      i_q        <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      word_cnt_q <= word_cnt_d;
      j_q        <= j_d;
      i_q        <= i_d;
    end
  end

endmodule
